cfg_reg_arbiter: RTL and testbench

CFG_REG_ARBITER -- requirements
Module: cfg_reg_arbiter

---
 rtl/cfg_reg_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cfg_reg_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_reg_arbiter.sv
// cfg_reg_arbiter: two-requester, round-robin arbiter that owns a small
// configuration register file (channel enables, PWM-mode selects, PWM duty).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid/a_addr/a_data      write request from A (SPI-decoded transaction)
//   b_valid/b_addr/b_data      write request from B (on-chip sequencer)
//   a_ready/b_ready            write-accepted pulse for the granted requester
//   wr_err                     pulse alongside ready when the write was not applied
//   en_out[15:0]               per-channel output enables   (0x00 low, 0x01 high)
//   en_pwm_mode[15:0]          per-channel PWM-mode select  (0x02 low, 0x03 high)
//   pwm_duty[7:0]              shared duty cycle            (0x04)
//
// Build option
//   CFG_ARB_LOCK_EN            adds a lock bit at 0x05 (written by A only);
//                              when set, B writes to 0x00-0x05 are refused.
//
// a_ready/b_ready/wr_err are decoded from the GRANT state and the winner's
// live valid/addr, so a requester that withdraws during GRANT gets no pulse.
// The register file itself is fully registered.

module cfg_reg_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [6:0]  a_addr,
    input  logic [7:0]  a_data,
    input  logic        b_valid,
    input  logic [6:0]  b_addr,
    input  logic [7:0]  b_data,
    output logic        a_ready,
    output logic        b_ready,
    output logic        wr_err,
    output logic [15:0] en_out,
    output logic [15:0] en_pwm_mode,
    output logic [7:0]  pwm_duty
);

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CH_W   = 16;

    localparam logic [ADDR_W-1:0] ADDR_EN_LO  = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] ADDR_EN_HI  = ADDR_W'(8'h01);
    localparam logic [ADDR_W-1:0] ADDR_PWM_LO = ADDR_W'(8'h02);
    localparam logic [ADDR_W-1:0] ADDR_PWM_HI = ADDR_W'(8'h03);
    localparam logic [ADDR_W-1:0] ADDR_DUTY   = ADDR_W'(8'h04);
`ifdef CFG_ARB_LOCK_EN
    localparam logic [ADDR_W-1:0] ADDR_LOCK   = ADDR_W'(8'h05);
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                win_b_q, win_b_d;    // 1: B holds the current grant
    logic                prio_b_q, prio_b_d;  // 1: B wins the next tie
    logic [CH_W-1:0]     en_out_q, en_out_d;
    logic [CH_W-1:0]     en_pwm_q, en_pwm_d;
    logic [DATA_W-1:0]   duty_q, duty_d;

    // Winner's request as seen during GRANT
    logic                sel_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                addr_mapped;
    logic                wr_blocked;

    assign sel_valid = win_b_q ? b_valid : a_valid;
    assign sel_addr  = win_b_q ? b_addr  : a_addr;
    assign sel_data  = win_b_q ? b_data  : a_data;

`ifdef CFG_ARB_LOCK_EN
    logic lock_q, lock_d;

    // B may never write the lock itself, and is shut out entirely while locked
    assign addr_mapped = (sel_addr <= ADDR_LOCK);
    assign wr_blocked  = win_b_q && addr_mapped && (lock_q || (sel_addr == ADDR_LOCK));
`else
    assign addr_mapped = (sel_addr <= ADDR_DUTY);
    assign wr_blocked  = 1'b0;
`endif

    // State, arbitration and register file flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_b_q  <= 1'b0;
            prio_b_q <= 1'b0;
            en_out_q <= '0;
            en_pwm_q <= '0;
            duty_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_b_q  <= win_b_d;
            prio_b_q <= prio_b_d;
            en_out_q <= en_out_d;
            en_pwm_q <= en_pwm_d;
            duty_q   <= duty_d;
        end
    end

`ifdef CFG_ARB_LOCK_EN
    // Lock bit flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    // Next-state, arbitration, write decode and accept pulses
    always_comb begin
        state_d  = state_q;
        win_b_d  = win_b_q;
        prio_b_d = prio_b_q;
        en_out_d = en_out_q;
        en_pwm_d = en_pwm_q;
        duty_d   = duty_q;
`ifdef CFG_ARB_LOCK_EN
        lock_d   = lock_q;
`endif
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        wr_err   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (a_valid || b_valid) begin
                    state_d = GRANT;
                    win_b_d = (a_valid && b_valid) ? prio_b_q : b_valid;
                end
            end
            GRANT: begin
                state_d = IDLE;
                if (sel_valid) begin
                    a_ready  = !win_b_q;
                    b_ready  = win_b_q;
                    // Pointer moves only on a completed grant
                    prio_b_d = !win_b_q;
                    if (!addr_mapped || wr_blocked) begin
                        wr_err = 1'b1;
                    end else begin
                        case (sel_addr)
                            ADDR_EN_LO:  en_out_d[7:0]  = sel_data;
                            ADDR_EN_HI:  en_out_d[15:8] = sel_data;
                            ADDR_PWM_LO: en_pwm_d[7:0]  = sel_data;
                            ADDR_PWM_HI: en_pwm_d[15:8] = sel_data;
                            ADDR_DUTY:   duty_d         = sel_data;
`ifdef CFG_ARB_LOCK_EN
                            ADDR_LOCK:   lock_d         = sel_data[0];
`endif
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign en_out      = en_out_q;
    assign en_pwm_mode = en_pwm_q;
    assign pwm_duty    = duty_q;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// tb_cfg_reg_arbiter: directed scenarios with a scoreboard. Each request
// pushes its expected accept (who, wr_err, register file afterwards); a
// monitor pops and compares whenever a ready pulse appears.

module tb_cfg_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [6:0]  a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic        a_ready, b_ready, wr_err;
    logic [15:0] en_out, en_pwm_mode;
    logic [7:0]  pwm_duty;

    typedef struct packed {
        logic        is_b;
        logic        err;
        logic [15:0] en;
        logic [15:0] pwm;
        logic [7:0]  duty;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef CFG_ARB_LOCK_EN
    localparam logic [15:0] EN6 = 16'h2211;
`else
    localparam logic [15:0] EN6 = 16'h2233;
`endif

    always #5 clk = ~clk;

    cfg_reg_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .a_ready     (a_ready),
        .b_ready     (b_ready),
        .wr_err      (wr_err),
        .en_out      (en_out),
        .en_pwm_mode (en_pwm_mode),
        .pwm_duty    (pwm_duty)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic is_b, input logic err, input logic [15:0] en,
                        input logic [15:0] pwm, input logic [7:0] duty);
        exp_t e;
        e.is_b = is_b;
        e.err  = err;
        e.en   = en;
        e.pwm  = pwm;
        e.duty = duty;
        sb_q.push_back(e);
    endtask

    // Drive one request and hold it until its ready (bounded wait)
    task automatic req(input logic is_b, input logic [6:0] addr, input logic [7:0] data);
        logic got;
        got = 1'b0;
        if (is_b) begin
            b_valid = 1'b1; b_addr = addr; b_data = data;
        end else begin
            a_valid = 1'b1; a_addr = addr; a_data = data;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = is_b ? b_ready : a_ready;
        end
        if (!got) chk(is_b ? "req_timeout_b" : "req_timeout_a", 16'h0, 16'h1);
        @(posedge clk);
        #1;
        if (is_b) b_valid = 1'b0;
        else      a_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk_regs(input string tag, input logic [15:0] en,
                            input logic [15:0] pwm, input logic [7:0] duty);
        chk({tag, "_en_out"}, en_out, en);
        chk({tag, "_en_pwm_mode"}, en_pwm_mode, pwm);
        chk({tag, "_pwm_duty"}, 16'(pwm_duty), 16'(duty));
    endtask

    // Monitor: every ready pulse must match the head of the scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (a_ready || b_ready)) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ready", {14'h0, b_ready, a_ready}, 16'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ready_who", {14'h0, b_ready, a_ready}, e.is_b ? 16'h2 : 16'h1);
                    chk("wr_err_on_ready", 16'(wr_err), 16'(e.err));
                    @(negedge clk);
                    chk_regs("after_write", e.en, e.pwm, e.duty);
                end
            end else if (rst_n) begin
                chk("wr_err_no_ready", 16'(wr_err), 16'h0);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk_regs("reset", 16'h0000, 16'h0000, 8'h00);
        chk("reset_a_ready", 16'(a_ready), 16'h0);
        chk("reset_b_ready", 16'(b_ready), 16'h0);
        chk("reset_wr_err", 16'(wr_err), 16'h0);

        // A alone writes duty
        push(1'b0, 1'b0, 16'h0000, 16'h0000, 8'h80);
        req(1'b0, 7'h04, 8'h80);

        // Simultaneous after reset: A first, then B
        do_reset();
        push(1'b0, 1'b0, 16'h0011, 16'h0000, 8'h00);
        push(1'b1, 1'b0, 16'h2211, 16'h0000, 8'h00);
        fork
            req(1'b0, 7'h00, 8'h11);
            req(1'b1, 7'h01, 8'h22);
        join

        // B to unmapped address
        push(1'b1, 1'b1, 16'h2211, 16'h0000, 8'h00);
        req(1'b1, 7'h40, 8'hFF);

        // Simultaneous again: B was last, so A goes first
        push(1'b0, 1'b0, 16'h2211, 16'h000F, 8'h00);
        push(1'b1, 1'b0, 16'h2211, 16'hF00F, 8'h00);
        fork
            req(1'b0, 7'h02, 8'h0F);
            req(1'b1, 7'h03, 8'hF0);
        join

        // Address 0x05 by A, then B to 0x00
`ifdef CFG_ARB_LOCK_EN
        push(1'b0, 1'b0, 16'h2211, 16'hF00F, 8'h00);
        req(1'b0, 7'h05, 8'h01);
        push(1'b1, 1'b1, 16'h2211, 16'hF00F, 8'h00);
        req(1'b1, 7'h00, 8'h33);
`else
        push(1'b0, 1'b1, 16'h2211, 16'hF00F, 8'h00);
        req(1'b0, 7'h05, 8'h01);
        push(1'b1, 1'b0, 16'h2233, 16'hF00F, 8'h00);
        req(1'b1, 7'h00, 8'h33);
`endif

        // A withdraws before GRANT: no ready, no write
        @(posedge clk);
        #1 a_valid = 1'b1; a_addr = 7'h04; a_data = 8'h77;
        @(posedge clk);
        #1 a_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_regs("withdraw", EN6, 16'hF00F, 8'h00);
        push(1'b0, 1'b0, EN6, 16'hF00F, 8'h3C);
        req(1'b0, 7'h04, 8'h3C);

        // Reset during GRANT discards the write
        @(posedge clk);
        #1 a_valid = 1'b1; a_addr = 7'h02; a_data = 8'h5A;
        @(posedge clk);
        #1 rst_n = 1'b0; a_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_regs("reset_in_grant", 16'h0000, 16'h0000, 8'h00);

        // Arbitration resumes after reset
        push(1'b0, 1'b0, 16'hAB00, 16'h0000, 8'h00);
        req(1'b0, 7'h01, 8'hAB);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", 16'(sb_q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
